// File: rtl/branch_flag_ctrl.sv
// Branch resolution controller: owns the NZCV flag register, resolves B/CBZ/CBNZ/B.cond,
// and stalls B.cond on in-flight flags with a bounded wait.
//
// state      | meaning
// IDLE       | ready for a branch request
// RESOLVE    | one-cycle response using captured operands and flags_q
// WAIT_FLAGS | B.cond held until new flags arrive or the wait bound expires
module branch_flag_ctrl #(
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 7
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_alu_flags_valid,
    input  logic [3:0]        i_alu_flags,
    input  logic              i_flags_pending,
    input  logic              i_br_valid,
    output logic              o_br_ready,
    input  logic [1:0]        i_br_type,
    input  logic [3:0]        i_br_cond,
    input  logic [DATA_W-1:0] i_cbz_operand,
    output logic              o_resp_valid,
    output logic              o_resp_taken,
    output logic              o_stall,
    output logic              o_wait_timeout,
    output logic [3:0]        o_flags_q
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESOLVE    = 2'd1,
        WAIT_FLAGS = 2'd2
    } state_t;

    localparam logic [1:0] BT_B     = 2'b00;
    localparam logic [1:0] BT_CBZ   = 2'b01;
    localparam logic [1:0] BT_CBNZ  = 2'b10;
    localparam logic [1:0] BT_BCOND = 2'b11;
    localparam logic [7:0] MAX_W    = 8'(MAX_WAIT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_flags;
    logic [1:0]  r_type;
    logic [3:0]  r_cond;
    logic        r_zero;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic        r_timeout;
    logic        w_set_timeout;
    logic        w_ready;
    logic        w_resp_valid;
    logic        w_stall;
    logic        w_accept;
    logic        w_cond_true;
    logic        w_taken;

    assign w_accept = i_br_valid && (r_state == IDLE);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= IDLE;
            r_flags   <= 4'b0000;
            r_type    <= BT_B;
            r_cond    <= 4'b0000;
            r_zero    <= 1'b0;
            r_cnt     <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (i_alu_flags_valid)
                r_flags <= i_alu_flags;
            if (w_accept) begin
                r_type <= i_br_type;
                r_cond <= i_br_cond;
                r_zero <= (i_cbz_operand == '0);
            end
            if (w_set_timeout)
                r_timeout <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_set_timeout = 1'b0;
        w_ready       = 1'b0;
        w_resp_valid  = 1'b0;
        w_stall       = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (w_accept) begin
                    // Flags landing in the accept cycle are already in flags_q at RESOLVE.
                    if (i_br_type != BT_BCOND || !i_flags_pending || i_alu_flags_valid)
                        w_state_nxt = RESOLVE;
                    else
                        w_state_nxt = WAIT_FLAGS;
                end
            end
            RESOLVE: begin
                w_resp_valid = 1'b1;
                w_state_nxt  = IDLE;
            end
            WAIT_FLAGS: begin
                w_stall = 1'b1;
                if (i_alu_flags_valid) begin
                    w_state_nxt = RESOLVE;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt + 8'd1 == MAX_W) begin
                    w_set_timeout = 1'b1;
                    w_state_nxt   = RESOLVE;
                    w_cnt_nxt     = 8'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // flags_q layout is {N,Z,C,V}
    always_comb begin
        w_cond_true = 1'b0;
        case (r_cond)
            4'b0000: w_cond_true = r_flags[2];
            4'b0001: w_cond_true = !r_flags[2];
            4'b1010: w_cond_true = (r_flags[3] == r_flags[0]);
            4'b1011: w_cond_true = (r_flags[3] != r_flags[0]);
            4'b1110: w_cond_true = 1'b1;
            default: w_cond_true = 1'b0;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (r_type)
            BT_B:     w_taken = 1'b1;
            BT_CBZ:   w_taken = r_zero;
            BT_CBNZ:  w_taken = !r_zero;
            BT_BCOND: w_taken = w_cond_true;
            default:  w_taken = 1'b0;
        endcase
    end

    assign o_br_ready     = w_ready;
    assign o_resp_valid   = w_resp_valid;
    assign o_resp_taken   = w_resp_valid & w_taken;
    assign o_stall        = w_stall;
    assign o_wait_timeout = r_timeout;
    assign o_flags_q      = r_flags;

endmodule

// File: tb/tb_branch_flag_ctrl.sv
// Directed bench for branch_flag_ctrl: hand-computed expectations checked with immediate assertions.
module tb_branch_flag_ctrl;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_alu_flags_valid;
    logic [3:0]  i_alu_flags;
    logic        i_flags_pending;
    logic        i_br_valid;
    logic        o_br_ready;
    logic [1:0]  i_br_type;
    logic [3:0]  i_br_cond;
    logic [63:0] i_cbz_operand;
    logic        o_resp_valid;
    logic        o_resp_taken;
    logic        o_stall;
    logic        o_wait_timeout;
    logic [3:0]  o_flags_q;

    int n_chk  = 0;
    int n_fail = 0;

    branch_flag_ctrl #(.DATA_W(64), .MAX_WAIT(7)) dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_alu_flags_valid (i_alu_flags_valid),
        .i_alu_flags       (i_alu_flags),
        .i_flags_pending   (i_flags_pending),
        .i_br_valid        (i_br_valid),
        .o_br_ready        (o_br_ready),
        .i_br_type         (i_br_type),
        .i_br_cond         (i_br_cond),
        .i_cbz_operand     (i_cbz_operand),
        .o_resp_valid      (o_resp_valid),
        .o_resp_taken      (o_resp_taken),
        .o_stall           (o_stall),
        .o_wait_timeout    (o_wait_timeout),
        .o_flags_q         (o_flags_q)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single accept edge; optional flags in the same cycle.
    task automatic issue(input logic [1:0] t, input logic [3:0] c, input logic [63:0] op,
                         input logic pend, input logic fv, input logic [3:0] f);
        i_br_valid        = 1'b1;
        i_br_type         = t;
        i_br_cond         = c;
        i_cbz_operand     = op;
        i_flags_pending   = pend;
        i_alu_flags_valid = fv;
        i_alu_flags       = f;
        tick();
        i_br_valid        = 1'b0;
        i_alu_flags_valid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic taken);
        chk({tag, " resp_valid"}, 64'(o_resp_valid), 64'd1);
        chk({tag, " taken"}, 64'(o_resp_taken), 64'(taken));
        chk({tag, " ready_low"}, 64'(o_br_ready), 64'd0);
        tick();
        chk({tag, " resp_drop"}, 64'(o_resp_valid), 64'd0);
        chk({tag, " ready_back"}, 64'(o_br_ready), 64'd1);
    endtask

    task automatic set_flags(input logic [3:0] f);
        i_alu_flags_valid = 1'b1;
        i_alu_flags       = f;
        tick();
        i_alu_flags_valid = 1'b0;
        chk("flags_load", 64'(o_flags_q), 64'(f));
    endtask

    initial begin
        i_reset           = 1'b0;
        i_alu_flags_valid = 1'b0;
        i_alu_flags       = 4'b0000;
        i_flags_pending   = 1'b0;
        i_br_valid        = 1'b0;
        i_br_type         = 2'b00;
        i_br_cond         = 4'b0000;
        i_cbz_operand     = 64'd0;
        #12;
        chk("rst stall", 64'(o_stall), 64'd0);
        chk("rst resp_valid", 64'(o_resp_valid), 64'd0);
        chk("rst taken", 64'(o_resp_taken), 64'd0);
        chk("rst flags", 64'(o_flags_q), 64'd0);
        chk("rst timeout", 64'(o_wait_timeout), 64'd0);
        @(negedge i_clk);
        i_reset = 1'b1;
        tick();
        chk("post_rst ready", 64'(o_br_ready), 64'd1);

        // CBZ / CBNZ full-width zero detect
        issue(2'b01, 4'd0, 64'h0, 1'b0, 1'b0, 4'd0);
        expect_resp("cbz_zero", 1'b1);
        issue(2'b01, 4'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 4'd0);
        expect_resp("cbz_msb", 1'b0);
        issue(2'b10, 4'd0, 64'h1, 1'b0, 1'b0, 4'd0);
        expect_resp("cbnz_one", 1'b1);
        issue(2'b10, 4'd0, 64'h0, 1'b0, 1'b0, 4'd0);
        expect_resp("cbnz_zero", 1'b0);
        issue(2'b00, 4'd0, 64'h0, 1'b0, 1'b0, 4'd0);
        expect_resp("b_uncond", 1'b1);

        // B.cond with flags already present
        set_flags(4'b0100);
        issue(2'b11, 4'b0000, 64'h0, 1'b0, 1'b0, 4'd0);
        expect_resp("eq_z", 1'b1);
        issue(2'b11, 4'b0001, 64'h0, 1'b0, 1'b0, 4'd0);
        expect_resp("ne_z", 1'b0);
        issue(2'b11, 4'b1110, 64'h0, 1'b0, 1'b0, 4'd0);
        expect_resp("al", 1'b1);
        set_flags(4'b1000);
        issue(2'b11, 4'b1011, 64'h0, 1'b0, 1'b0, 4'd0);
        expect_resp("lt_n", 1'b1);
        issue(2'b11, 4'b1010, 64'h0, 1'b0, 1'b0, 4'd0);
        expect_resp("ge_n", 1'b0);
        issue(2'b11, 4'b0010, 64'h0, 1'b0, 1'b0, 4'd0);
        expect_resp("never", 1'b0);

        // Flags arrive in the accept cycle while pending: no wait, new flags used
        issue(2'b11, 4'b0000, 64'h0, 1'b1, 1'b1, 4'b0100);
        chk("same_cycle stall", 64'(o_stall), 64'd0);
        chk("same_cycle flags", 64'(o_flags_q), 64'h4);
        expect_resp("same_cycle", 1'b1);

        // LT waits three cycles for flags 1001 (N==V -> not taken)
        issue(2'b11, 4'b1011, 64'h0, 1'b1, 1'b0, 4'd0);
        chk("wait1 stall", 64'(o_stall), 64'd1);
        chk("wait1 ready", 64'(o_br_ready), 64'd0);
        chk("wait1 resp", 64'(o_resp_valid), 64'd0);
        tick();
        chk("wait2 stall", 64'(o_stall), 64'd1);
        tick();
        chk("wait3 stall", 64'(o_stall), 64'd1);
        i_alu_flags_valid = 1'b1;
        i_alu_flags       = 4'b1001;
        tick();
        i_alu_flags_valid = 1'b0;
        i_flags_pending   = 1'b0;
        chk("arrive stall", 64'(o_stall), 64'd0);
        chk("arrive flags", 64'(o_flags_q), 64'h9);
        chk("arrive timeout", 64'(o_wait_timeout), 64'd0);
        expect_resp("arrive_lt", 1'b0);

        // Flags on the final wait cycle beat the timeout
        issue(2'b11, 4'b0000, 64'h0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("edge7 stall", 64'(o_stall), 64'd1);
        i_alu_flags_valid = 1'b1;
        i_alu_flags       = 4'b0100;
        tick();
        i_alu_flags_valid = 1'b0;
        chk("edge_race timeout", 64'(o_wait_timeout), 64'd0);
        chk("edge_race flags", 64'(o_flags_q), 64'h4);
        expect_resp("edge_race", 1'b1);

        // Full timeout: 7 stall cycles, sticky timeout, old flags (Z=1, EQ taken)
        issue(2'b11, 4'b0000, 64'h0, 1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("to_wait%0d stall", i + 1), 64'(o_stall), 64'd1);
            chk($sformatf("to_wait%0d timeout", i + 1), 64'(o_wait_timeout), 64'd0);
            tick();
        end
        i_flags_pending = 1'b0;
        chk("to stall_drop", 64'(o_stall), 64'd0);
        chk("to timeout_set", 64'(o_wait_timeout), 64'd1);
        expect_resp("timeout_eq", 1'b1);
        chk("to sticky", 64'(o_wait_timeout), 64'd1);

        // Reset during WAIT_FLAGS abandons the request
        issue(2'b11, 4'b0001, 64'h0, 1'b1, 1'b0, 4'd0);
        chk("rw stall", 64'(o_stall), 64'd1);
        #2;
        i_reset = 1'b0;
        #1;
        chk("rw stall_clr", 64'(o_stall), 64'd0);
        chk("rw flags_clr", 64'(o_flags_q), 64'd0);
        chk("rw timeout_clr", 64'(o_wait_timeout), 64'd0);
        chk("rw resp", 64'(o_resp_valid), 64'd0);
        tick();
        chk("rw resp_hold", 64'(o_resp_valid), 64'd0);
        i_flags_pending = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b1;
        tick();
        chk("rw resp_after", 64'(o_resp_valid), 64'd0);
        chk("rw ready", 64'(o_br_ready), 64'd1);
        issue(2'b00, 4'd0, 64'h0, 1'b0, 1'b0, 4'd0);
        expect_resp("rw_b", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
